xoodyak_cmd_sequencer: RTL and testbench

Programmable command sequencer that stores a list of Xoodyak operations (opmode + input block) and replays them into `xoodyak_build`. Each entry is held for a fixed number of cycles, and the sequence can optionally loop. Core text outputs are captured into a tagged result FIFO. It replaces hard-wired opmode/data tables and wrapping counters with a synthesizable, loadable driver for the core.

---
 rtl/xoodyak_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_xoodyak_cmd_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoodyak_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xoodyak_cmd_sequencer
// Brief    : Loadable opmode/data sequencer for the Xoodyak core, with a tagged
//            first-word-fall-through result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module xoodyak_cmd_sequencer #(
    parameter int DATA_W    = 352,
    parameter int OPMODE_W  = 5,
    parameter int OUT_W     = 192,
    parameter int DEPTH     = 16,
    parameter int RES_DEPTH = 8,
    parameter int HOLD      = 4
) (
    input  logic                     eph1,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [OPMODE_W-1:0]      cmd_opmode,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     clear,
    input  logic                     run,
    input  logic                     loop,
    output logic [OPMODE_W-1:0]      core_opmode,
    output logic [DATA_W-1:0]        core_data,
    input  logic [OUT_W-1:0]         core_textout,
    input  logic                     core_textout_valid,
    output logic                     res_valid,
    output logic [OUT_W-1:0]         res_data,
    output logic [$clog2(DEPTH)-1:0] res_tag,
    input  logic                     res_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_rptr_w = $clog2(RES_DEPTH);
    localparam int c_hold_w = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD - 1);
    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_ptr_w-1:0]    r_rd_ptr, w_rd_ptr_nxt, w_rd_ptr_inc;
    logic [c_hold_w-1:0]   r_hold, w_hold_nxt;
    logic [c_cnt_w-1:0]    r_count;
    logic [OPMODE_W-1:0]   r_core_opmode, w_opmode_nxt;
    logic [DATA_W-1:0]     r_core_data, w_data_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_overflow;

    logic [OPMODE_W-1:0]   r_cmd_opmode [DEPTH];
    logic [DATA_W-1:0]     r_cmd_data   [DEPTH];
    logic [OUT_W-1:0]      r_res_data   [RES_DEPTH];
    logic [c_ptr_w-1:0]    r_res_tag    [RES_DEPTH];
    logic [c_rptr_w:0]     r_res_wr, r_res_rd;

    logic w_idle, w_clear, w_cmd_wr, w_hold_last, w_last_entry;
    logic w_res_empty, w_res_full, w_pop, w_push;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_clear      = clear & w_idle;
    assign cmd_ready    = w_idle & (r_count < c_depth);
    assign w_cmd_wr     = cmd_valid & cmd_ready & ~clear;
    assign w_hold_last  = (r_hold == c_hold_last);
    assign w_rd_ptr_inc = r_rd_ptr + c_ptr_w'(1);
    assign w_last_entry = (({1'b0, r_rd_ptr} + c_cnt_w'(1)) == r_count);

    // Core outputs are registered, so the next-cycle entry is selected here.
    always_comb begin
        w_state_nxt  = r_state;
        w_rd_ptr_nxt = r_rd_ptr;
        w_hold_nxt   = r_hold;
        w_opmode_nxt = '0;
        w_data_nxt   = '0;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run && (r_count != '0)) begin
                    w_state_nxt  = ST_ISSUE;
                    w_rd_ptr_nxt = '0;
                    w_hold_nxt   = '0;
                    w_opmode_nxt = r_cmd_opmode[0];
                    w_data_nxt   = r_cmd_data[0];
                end
            end
            ST_ISSUE: begin
                w_opmode_nxt = r_cmd_opmode[r_rd_ptr];
                w_data_nxt   = r_cmd_data[r_rd_ptr];
                if (w_hold_last) begin
                    w_hold_nxt = '0;
                    if (!w_last_entry) begin
                        w_rd_ptr_nxt = w_rd_ptr_inc;
                        w_opmode_nxt = r_cmd_opmode[w_rd_ptr_inc];
                        w_data_nxt   = r_cmd_data[w_rd_ptr_inc];
                    end else if (loop && run) begin
                        w_rd_ptr_nxt = '0;
                        w_opmode_nxt = r_cmd_opmode[0];
                        w_data_nxt   = r_cmd_data[0];
                    end else begin
                        // rd_ptr returns to 0 so results tagged in IDLE read 0.
                        w_state_nxt  = ST_IDLE;
                        w_rd_ptr_nxt = '0;
                        w_opmode_nxt = '0;
                        w_data_nxt   = '0;
                        w_done_nxt   = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold + c_hold_w'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_rd_ptr      <= '0;
            r_hold        <= '0;
            r_core_opmode <= '0;
            r_core_data   <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_hold        <= w_hold_nxt;
            r_core_opmode <= w_opmode_nxt;
            r_core_data   <= w_data_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_ff @(posedge eph1) begin
        if (w_cmd_wr) begin
            r_cmd_opmode[r_count[c_ptr_w-1:0]] <= cmd_opmode;
            r_cmd_data[r_count[c_ptr_w-1:0]]   <= cmd_data;
        end
    end

    // Result FIFO: a push into a full FIFO is still accepted when the head
    // is popped in the same cycle.
    assign w_res_empty = (r_res_wr == r_res_rd);
    assign w_res_full  = (r_res_wr[c_rptr_w] != r_res_rd[c_rptr_w]) &&
                         (r_res_wr[c_rptr_w-1:0] == r_res_rd[c_rptr_w-1:0]);
    assign w_pop       = res_ready & ~w_res_empty;
    assign w_push      = core_textout_valid & (~w_res_full | w_pop);

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_res_wr   <= '0;
            r_res_rd   <= '0;
        end else begin
            if (w_clear)
                r_count <= '0;
            else if (w_cmd_wr)
                r_count <= r_count + c_cnt_w'(1);
            if (core_textout_valid && !w_push)
                r_overflow <= 1'b1;
            else if (w_clear)
                r_overflow <= 1'b0;
            if (w_push)
                r_res_wr <= r_res_wr + (c_rptr_w + 1)'(1);
            if (w_pop)
                r_res_rd <= r_res_rd + (c_rptr_w + 1)'(1);
        end
    end

    always_ff @(posedge eph1) begin
        if (w_push) begin
            r_res_data[r_res_wr[c_rptr_w-1:0]] <= core_textout;
            r_res_tag[r_res_wr[c_rptr_w-1:0]]  <= r_rd_ptr;
        end
    end

    assign core_opmode = r_core_opmode;
    assign core_data   = r_core_data;
    assign busy        = ~w_idle;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign res_valid   = ~w_res_empty;
    assign res_data    = r_res_data[r_res_rd[c_rptr_w-1:0]];
    assign res_tag     = r_res_tag[r_res_rd[c_rptr_w-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_xoodyak_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xoodyak_cmd_sequencer
// Brief    : Scoreboard bench for xoodyak_cmd_sequencer (HOLD=4, RES_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_xoodyak_cmd_sequencer;

    localparam int DATA_W    = 352;
    localparam int OPMODE_W  = 5;
    localparam int OUT_W     = 192;
    localparam int DEPTH     = 16;
    localparam int RES_DEPTH = 4;
    localparam int HOLD      = 4;
    localparam int TAG_W     = $clog2(DEPTH);

    logic                eph1 = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [OPMODE_W-1:0] cmd_opmode = '0;
    logic [DATA_W-1:0]   cmd_data = '0;
    logic                clear = 1'b0;
    logic                run = 1'b0;
    logic                loop = 1'b0;
    logic [OPMODE_W-1:0] core_opmode;
    logic [DATA_W-1:0]   core_data;
    logic [OUT_W-1:0]    core_textout = '0;
    logic                core_textout_valid = 1'b0;
    logic                res_valid;
    logic [OUT_W-1:0]    res_data;
    logic [TAG_W-1:0]    res_tag;
    logic                res_ready = 1'b0;
    logic                busy;
    logic                done;
    logic                overflow;

    int checks = 0;
    int failures = 0;

    logic [OPMODE_W-1:0] exp_op_q   [$];
    logic [DATA_W-1:0]   exp_data_q [$];
    logic [OUT_W-1:0]    exp_res_q  [$];
    logic [TAG_W-1:0]    exp_tag_q  [$];

    xoodyak_cmd_sequencer #(
        .DATA_W(DATA_W), .OPMODE_W(OPMODE_W), .OUT_W(OUT_W),
        .DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH), .HOLD(HOLD)
    ) dut (
        .eph1(eph1), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opmode(cmd_opmode), .cmd_data(cmd_data),
        .clear(clear), .run(run), .loop(loop),
        .core_opmode(core_opmode), .core_data(core_data),
        .core_textout(core_textout), .core_textout_valid(core_textout_valid),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .res_ready(res_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 eph1 = ~eph1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DATA_W-1:0] mk_data(input int s);
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++)
            v[i*32 +: 32] = 32'(s * 32'h0100_0193 + i * 32'h0001_0001 + 32'h5A00_0000);
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] mk_text(input int s);
        logic [OUT_W-1:0] v;
        for (int i = 0; i < OUT_W / 32; i++)
            v[i*32 +: 32] = 32'(s * 32'h0019_660D + i * 32'h0101_0000 + 32'hC300_0000);
        return v;
    endfunction

    task automatic step();
        @(posedge eph1);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic load_cmd(input logic [OPMODE_W-1:0] op, input logic [DATA_W-1:0] d);
        cmd_valid  = 1'b1;
        cmd_opmode = op;
        cmd_data   = d;
        step();
        cmd_valid  = 1'b0;
        exp_op_q.push_back(op);
        exp_data_q.push_back(d);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++;
        if ({core_opmode, busy, done, res_valid, overflow} !== '0 || core_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got op=%h busy=%b done=%b rv=%b ovf=%b required all zero",
                     core_opmode, busy, done, res_valid, overflow);
        end
        #3 reset = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_sequence();
        logic [OPMODE_W-1:0] cur_op;
        logic [DATA_W-1:0]   cur_d;
        cur_op = '0;
        cur_d  = '0;
        do_clear();
        load_cmd(5'h10, mk_data(1));
        load_cmd(5'h11, mk_data(2));
        load_cmd(5'h13, mk_data(3));
        pulse_run();
        for (int c = 1; c <= 3 * HOLD; c++) begin
            if ((c - 1) % HOLD == 0) begin
                cur_op = exp_op_q.pop_front();
                cur_d  = exp_data_q.pop_front();
            end
            checks++;
            if ({core_opmode, busy, done} !== {cur_op, 1'b1, 1'b0} || core_data !== cur_d) begin
                failures++;
                $display("FAIL seq_cycle%0d: got op=%h busy=%b done=%b required op=%h busy=1 done=0",
                         c, core_opmode, busy, done, cur_op);
            end
            step();
        end
        checks++;
        if ({core_opmode, busy, done} !== {5'h00, 1'b0, 1'b1} || core_data !== '0) begin
            failures++;
            $display("FAIL seq_end: got op=%h busy=%b done=%b required op=00 busy=0 done=1",
                     core_opmode, busy, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL seq_done_pulse: got done=%b required 0", done);
        end
    endtask

    task automatic test_full_clear();
        logic [OPMODE_W-1:0] cur_op;
        logic [DATA_W-1:0]   cur_d;
        cur_op = '0;
        cur_d  = '0;
        do_clear();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready%0d: got %b required 1", i, cmd_ready);
            end
            load_cmd(5'h08, mk_data(100 + i));
        end
        exp_op_q.delete();
        exp_data_q.delete();
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: got %b required 0", cmd_ready);
        end
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready_17: got %b required 0", cmd_ready);
        end
        // clear and a write in the same cycle: the write must be discarded
        clear = 1'b1;
        cmd_valid = 1'b1;
        cmd_opmode = 5'h1F;
        cmd_data = mk_data(999);
        step();
        clear = 1'b0;
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_ready: got %b required 1", cmd_ready);
        end
        load_cmd(5'h05, mk_data(200));
        load_cmd(5'h06, mk_data(201));
        pulse_run();
        for (int c = 1; c <= 2 * HOLD; c++) begin
            if ((c - 1) % HOLD == 0) begin
                cur_op = exp_op_q.pop_front();
                cur_d  = exp_data_q.pop_front();
            end
            checks++;
            if ({core_opmode, busy} !== {cur_op, 1'b1} || core_data !== cur_d) begin
                failures++;
                $display("FAIL rerun_cycle%0d: got op=%h busy=%b required op=%h busy=1",
                         c, core_opmode, busy, cur_op);
            end
            step();
        end
        checks++;
        if ({core_opmode, busy, done} !== {5'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rerun_end: got op=%h busy=%b done=%b required op=00 busy=0 done=1",
                     core_opmode, busy, done);
        end
    endtask

    task automatic test_loop();
        logic [OPMODE_W-1:0] cur_op;
        logic [DATA_W-1:0]   cur_d;
        cur_op = '0;
        cur_d  = '0;
        do_clear();
        load_cmd(5'h03, mk_data(300));
        load_cmd(5'h04, mk_data(301));
        for (int p = 0; p < 2; p++) begin
            exp_op_q.push_back(5'h03);
            exp_data_q.push_back(mk_data(300));
            exp_op_q.push_back(5'h04);
            exp_data_q.push_back(mk_data(301));
        end
        loop = 1'b1;
        run  = 1'b1;
        step();
        for (int c = 0; c < 6 * HOLD; c++) begin
            if (c % HOLD == 0) begin
                cur_op = exp_op_q.pop_front();
                cur_d  = exp_data_q.pop_front();
            end
            checks++;
            if ({core_opmode, busy, done} !== {cur_op, 1'b1, 1'b0} || core_data !== cur_d) begin
                failures++;
                $display("FAIL loop_cycle%0d: got op=%h busy=%b done=%b required op=%h busy=1 done=0",
                         c, core_opmode, busy, done, cur_op);
            end
            if (c == 18) run = 1'b0;
            step();
        end
        checks++;
        if ({core_opmode, busy, done} !== {5'h00, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL loop_end: got op=%h busy=%b done=%b required op=00 busy=0 done=1",
                     core_opmode, busy, done);
        end
        loop = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        int occ;
        logic exp_ovf;
        int guard;
        occ = 0;
        exp_ovf = 1'b0;
        do_clear();
        res_ready = 1'b0;
        load_cmd(5'h01, mk_data(400));
        load_cmd(5'h02, mk_data(401));
        load_cmd(5'h03, mk_data(402));
        exp_op_q.delete();
        exp_data_q.delete();
        pulse_run();
        for (int c = 1; c <= 3 * HOLD; c++) begin
            if (c == 2 || c == 3) begin
                checks++;
                if (res_valid !== (c == 3)) begin
                    failures++;
                    $display("FAIL ovf_res_valid_c%0d: got %b required %b", c, res_valid, c == 3);
                end
            end
            if (c == 2 || c == 4 || c == 6 || c == 9 || c == 11) begin
                core_textout_valid = 1'b1;
                core_textout = mk_text(c);
                if (occ < RES_DEPTH) begin
                    exp_res_q.push_back(mk_text(c));
                    exp_tag_q.push_back(TAG_W'((c - 1) / HOLD));
                    occ++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end else begin
                core_textout_valid = 1'b0;
            end
            step();
        end
        core_textout_valid = 1'b0;
        checks++;
        if ({done, overflow} !== {1'b1, exp_ovf}) begin
            failures++;
            $display("FAIL ovf_flag: got done=%b ovf=%b required done=1 ovf=%b", done, overflow, exp_ovf);
        end
        res_ready = 1'b1;
        guard = 0;
        while (exp_res_q.size() > 0) begin
            logic [OUT_W-1:0] ed;
            logic [TAG_W-1:0] et;
            ed = exp_res_q.pop_front();
            et = exp_tag_q.pop_front();
            checks++;
            if (res_valid !== 1'b1 || res_data !== ed || res_tag !== et) begin
                failures++;
                $display("FAIL ovf_drain%0d: got v=%b tag=%0d data=%h required v=1 tag=%0d data=%h",
                         guard, res_valid, res_tag, res_data, et, ed);
            end
            step();
            guard++;
            if (guard > 2 * RES_DEPTH) break;
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drained_empty: got res_valid=%b required 0", res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_clear();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL clear_overflow: got %b required 0", overflow);
        end
        res_ready = 1'b0;
        for (int i = 0; i < RES_DEPTH; i++) begin
            core_textout_valid = 1'b1;
            core_textout = mk_text(50 + i);
            exp_res_q.push_back(mk_text(50 + i));
            exp_tag_q.push_back('0);
            step();
        end
        core_textout_valid = 1'b1;
        core_textout = mk_text(60);
        res_ready = 1'b1;
        checks++;
        if (res_valid !== 1'b1 || res_data !== exp_res_q[0]) begin
            failures++;
            $display("FAIL fullpop_head: got v=%b data=%h required v=1 data=%h",
                     res_valid, res_data, exp_res_q[0]);
        end
        void'(exp_res_q.pop_front());
        void'(exp_tag_q.pop_front());
        exp_res_q.push_back(mk_text(60));
        exp_tag_q.push_back('0);
        step();
        core_textout_valid = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_overflow: got %b required 0", overflow);
        end
        res_ready = 1'b1;
        for (int i = 0; i < RES_DEPTH; i++) begin
            logic [OUT_W-1:0] ed;
            logic [TAG_W-1:0] et;
            ed = exp_res_q.pop_front();
            et = exp_tag_q.pop_front();
            checks++;
            if (res_valid !== 1'b1 || res_data !== ed || res_tag !== et) begin
                failures++;
                $display("FAIL fullpop_drain%0d: got v=%b tag=%0d data=%h required v=1 tag=%0d data=%h",
                         i, res_valid, res_tag, res_data, et, ed);
            end
            step();
        end
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_occupancy: got res_valid=%b after 4 pops required 0", res_valid);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        load_cmd(5'h0A, mk_data(500));
        load_cmd(5'h0B, mk_data(501));
        exp_op_q.delete();
        exp_data_q.delete();
        pulse_run();
        core_textout_valid = 1'b1;
        core_textout = mk_text(70);
        step();
        core_textout_valid = 1'b0;
        repeat (3) step();
        checks++;
        if ({busy, res_valid, core_opmode} !== {1'b1, 1'b1, 5'h0B}) begin
            failures++;
            $display("FAIL areset_pre: got busy=%b rv=%b op=%h required busy=1 rv=1 op=0b",
                     busy, res_valid, core_opmode);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({core_opmode, busy, done, res_valid, overflow} !== '0 || core_data !== '0) begin
            failures++;
            $display("FAIL areset_immediate: got op=%h busy=%b done=%b rv=%b ovf=%b required all zero",
                     core_opmode, busy, done, res_valid, overflow);
        end
        step();
        #2 reset = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_cmd_ready: got %b required 1", cmd_ready);
        end
        pulse_run();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if ({core_opmode, busy, done} !== '0) begin
                failures++;
                $display("FAIL areset_run_ignored%0d: got op=%h busy=%b done=%b required all zero",
                         c, core_opmode, busy, done);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_full_clear();
        test_loop();
        test_overflow();
        test_full_pop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
